output_collector: RTL

- Sits directly upstream of the gating module.
- Captures per-lane FP16 results from the 16-PE array. Lanes arrive skewed and independently.
- Assembles each complete set of 16 lanes into one 256-bit vector and buffers it in a small FIFO.
- Streams vectors to gating over valid/ready, tagging the final vector of a job with out_last.

---
 rtl/moe_pkg.sv | 16 +
 rtl/oc_vec_fifo.sv | 67 ++++++
 rtl/output_collector.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/moe_pkg.sv
// Shared widths and state encoding for the MoE datapath blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package moe_pkg;

    localparam int FP16_W = 16;
    localparam int NUM_PE = 16;
    localparam int VEC_W  = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } oc_state_t;

endpackage

// File: rtl/oc_vec_fifo.sv
// Synchronous first-word-fall-through FIFO holding assembled vectors.
// Latency: a push is visible on rdata the cycle after the write edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
//
// Ports: push/wdata write side, pop/rdata read side (rdata = head entry),
//        empty/full/count occupancy status.
module oc_vec_fifo #(
    parameter int W     = 257,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem[rd_ptr];

    // A same-cycle pop frees the slot being written, so full+pop+push is legal.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/output_collector.sv
// Gathers skewed per-lane PE results into full vectors and streams them to gating.
// Latency: last lane captured at edge t -> vector pushed at t+1 -> out_valid after t+1.
// Backpressure: full FIFO holds lane_full set, dropping lane_ready to stall the PEs.
//
// Ports: cfg_start/cfg_num_vec start a job (IDLE only); lane_valid/lane_data/lane_ready
//        per-lane capture; out_valid/out_ready/out_vec/out_last vector stream;
//        busy, done (drain pulse), err_idle (sticky lane activity while idle).
module output_collector
    import moe_pkg::*;
#(
    parameter int LANES = NUM_PE,
    parameter int DW    = FP16_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_start,
    input  logic [CNT_W-1:0]       cfg_num_vec,
    input  logic [LANES-1:0]       lane_valid,
    input  logic [LANES*DW-1:0]    lane_data,
    output logic [LANES-1:0]       lane_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*DW-1:0]    out_vec,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic                   err_idle
);

    localparam int VW = LANES * DW;
    localparam int CW = $clog2(DEPTH) + 1;

    oc_state_t                   state_q;
    oc_state_t                   state_d;
    logic [LANES-1:0]            lane_full_q;
    logic [LANES-1:0][DW-1:0]    lane_dat_q;
    logic [CNT_W:0]              remaining_q;
    logic                        err_idle_q;

    logic                        fifo_push;
    logic                        fifo_pop;
    logic                        fifo_empty;
    logic                        fifo_full;
    logic [CW-1:0]               fifo_count;
    logic [VW:0]                 fifo_wdata;
    logic [VW:0]                 fifo_rdata;
    logic                        is_last;
    logic                        start_job;
    logic [LANES-1:0]            capture;

    assign start_job  = (state_q == IDLE) && cfg_start;

    // Ready depends only on registered state, never on lane_valid.
    assign lane_ready = (state_q == COLLECT) ? ~lane_full_q : '0;
    assign capture    = lane_valid & lane_ready;

    assign is_last    = (remaining_q == (CNT_W+1)'(1));
    assign fifo_pop   = !fifo_empty && out_ready;
    assign fifo_push  = (state_q == COLLECT) && (&lane_full_q) && (!fifo_full || fifo_pop);
    assign fifo_wdata = {is_last, lane_dat_q};

    // Head is masked while empty so stale storage never leaks after reset.
    assign out_valid  = !fifo_empty;
    assign out_vec    = fifo_empty ? '0 : fifo_rdata[VW-1:0];
    assign out_last   = fifo_empty ? 1'b0 : fifo_rdata[VW];

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DRAIN) && fifo_empty;
    assign err_idle   = err_idle_q;

    oc_vec_fifo #(
        .W     (VW + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (fifo_push && is_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // DRAIN is entered on a push, so empty here means the final pop happened.
                if (fifo_count == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lane_full_q <= '0;
            remaining_q <= '0;
            err_idle_q  <= 1'b0;
        end else begin
            state_q <= state_d;

            if (fifo_push) begin
                lane_full_q <= '0;
            end else begin
                lane_full_q <= lane_full_q | capture;
            end

            if (start_job) begin
                remaining_q <= (cfg_num_vec == '0) ? {1'b1, {CNT_W{1'b0}}}
                                                   : {1'b0, cfg_num_vec};
            end else if (fifo_push) begin
                remaining_q <= remaining_q - (CNT_W+1)'(1);
            end

            // Starting a job clears the flag even if a stray lane_valid coincides.
            if (start_job) begin
                err_idle_q <= 1'b0;
            end else if ((state_q == IDLE) && (|lane_valid)) begin
                err_idle_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (capture[i]) begin
                lane_dat_q[i] <= lane_data[DW*i +: DW];
            end
        end
    end

endmodule
